// File: rtl/threshold_ctrl.sv
// threshold_ctrl
//   Frame-level scheduler for the binary threshold stage. Accumulates the
//   intensity sum and pixel count of each frame, divides them after frame end
//   (restoring divider, one quotient bit per cycle), adds a signed offset,
//   clamps, and hands the result to the threshold stage at the next frame start.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   frame_start/_end     one-cycle frame delimiters
//   data_valid, pixel_in tapped pixel stream
//   cfg_auto             1 = computed threshold, 0 = cfg_manual_thresh
//   cfg_manual_thresh    manual threshold
//   cfg_offset           signed offset added to the mean
//   threshold_val        threshold presented to the stage (changes at frame_start)
//   thresh_update        pulse when threshold_val is loaded
//   mean_out/mean_valid  last computed mean and its strobe
//   busy                 division in progress
//   overflow             pixel count saturated in the current frame
//
// state  | meaning
// IDLE   | waiting for frame_start
// ACCUM  | summing pixels of the current frame
// DIVIDE | computing sum/count, one quotient bit per cycle

module threshold_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int CNT_WIDTH   = 20,
  parameter int INIT_THRESH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  cfg_auto,
  input  logic [DATA_WIDTH-1:0] cfg_manual_thresh,
  input  logic [DATA_WIDTH:0]   cfg_offset,
  output logic [DATA_WIDTH-1:0] threshold_val,
  output logic                  thresh_update,
  output logic [DATA_WIDTH-1:0] mean_out,
  output logic                  mean_valid,
  output logic                  busy,
  output logic                  overflow
);

  localparam int SUM_WIDTH = DATA_WIDTH + CNT_WIDTH;
  localparam int DCW       = $clog2(SUM_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE} state_t;

  state_t                r_state, w_state_next;
  logic [SUM_WIDTH-1:0]  r_sum;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [SUM_WIDTH-1:0]  r_quot;     // dividend shifts out the top, quotient bits enter the bottom
  logic [CNT_WIDTH-1:0]  r_divisor;
  logic [CNT_WIDTH-1:0]  r_rem;
  logic [DCW-1:0]        r_div_cnt;
  logic [DATA_WIDTH-1:0] r_pending;
  logic                  r_pending_valid;

  logic                  w_take;
  logic                  w_drop;
  logic [SUM_WIDTH-1:0]  w_sum_acc;
  logic [CNT_WIDTH-1:0]  w_cnt_acc;
  logic [CNT_WIDTH:0]    w_rem_shift;
  logic                  w_ge;
  logic [CNT_WIDTH:0]    w_rem_sub;
  logic [CNT_WIDTH-1:0]  w_rem_next;
  logic [SUM_WIDTH-1:0]  w_quot_next;
  logic [DATA_WIDTH-1:0] w_mean;
  logic signed [DATA_WIDTH+1:0] w_adj;
  logic [DATA_WIDTH-1:0] w_clamped;
  logic                  w_div_last;

  // Accumulation of the current cycle's pixel (dropped once the count saturates)
  assign w_take    = data_valid && (r_count != CNT_MAX);
  assign w_drop    = data_valid && (r_count == CNT_MAX);
  assign w_sum_acc = r_sum + (w_take ? SUM_WIDTH'(pixel_in) : '0);
  assign w_cnt_acc = r_count + (w_take ? CNT_WIDTH'(1) : '0);

  // Restoring division step; remainder stays below the divisor so CNT_WIDTH bits suffice
  assign w_rem_shift = {r_rem, r_quot[SUM_WIDTH-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_divisor});
  assign w_rem_sub   = w_rem_shift - {1'b0, r_divisor};
  assign w_rem_next  = w_ge ? w_rem_sub[CNT_WIDTH-1:0] : w_rem_shift[CNT_WIDTH-1:0];
  assign w_quot_next = {r_quot[SUM_WIDTH-2:0], w_ge};
  assign w_mean      = w_quot_next[DATA_WIDTH-1:0];

  // Two guard bits: bit DATA_WIDTH+1 flags a negative result, bit DATA_WIDTH an overshoot
  assign w_adj     = $signed({2'b00, w_mean}) + $signed({cfg_offset[DATA_WIDTH], cfg_offset});
  assign w_clamped = w_adj[DATA_WIDTH+1] ? '0 :
                     w_adj[DATA_WIDTH]   ? '1 : w_adj[DATA_WIDTH-1:0];

  assign w_div_last = (r_state == DIVIDE) && !frame_start && (r_div_cnt == '0);

  always_comb begin
    w_state_next = r_state;
    if (frame_start) begin
      w_state_next = ACCUM;
    end else begin
      case (r_state)
        ACCUM:   if (frame_end) w_state_next = (w_cnt_acc == '0) ? IDLE : DIVIDE;
        DIVIDE:  if (r_div_cnt == '0) w_state_next = IDLE;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum           <= '0;
      r_count         <= '0;
      r_quot          <= '0;
      r_divisor       <= '0;
      r_rem           <= '0;
      r_div_cnt       <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      threshold_val   <= DATA_WIDTH'(INIT_THRESH);
      thresh_update   <= 1'b0;
      mean_out        <= '0;
      mean_valid      <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      thresh_update <= 1'b0;
      mean_valid    <= 1'b0;
      if (frame_start) begin
        // The first pixel may share the cycle with frame_start
        r_sum    <= data_valid ? SUM_WIDTH'(pixel_in) : '0;
        r_count  <= data_valid ? CNT_WIDTH'(1) : '0;
        overflow <= 1'b0;
        if (!cfg_auto) begin
          threshold_val <= cfg_manual_thresh;
          thresh_update <= 1'b1;
        end else if (r_pending_valid) begin
          threshold_val   <= r_pending;
          r_pending_valid <= 1'b0;
          thresh_update   <= 1'b1;
        end
      end else if (r_state == ACCUM) begin
        r_sum   <= w_sum_acc;
        r_count <= w_cnt_acc;
        if (w_drop) overflow <= 1'b1;
        if (frame_end) begin
          r_quot    <= w_sum_acc;
          r_divisor <= w_cnt_acc;
          r_rem     <= '0;
          r_div_cnt <= DCW'(SUM_WIDTH - 1);
        end
      end else if (r_state == DIVIDE) begin
        r_quot    <= w_quot_next;
        r_rem     <= w_rem_next;
        r_div_cnt <= r_div_cnt - DCW'(1);
        if (w_div_last) begin
          mean_out        <= w_mean;
          r_pending       <= w_clamped;
          r_pending_valid <= 1'b1;
          mean_valid      <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state == DIVIDE);

endmodule
